fb_fill_writer: RTL

Fills an axis-aligned rectangle of the 32-bit-per-pixel frame buffer in HPS SDRAM with a solid colour. It writes through the FPGA-to-HPS SDRAM Avalon-MM port, the same port the display read path uses to fetch pixels. It accepts one command at a time over a valid/ready handshake and issues pipelined write bursts of up to BURST_MAX 64-bit beats, with byte-masking at odd pixel edges. It sits between the graphics command logic and the SDRAM port arbiter.

---
 rtl/fb_fill_writer.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/fb_fill_writer.sv
// fb_fill_writer
//   Fills an axis-aligned rectangle of a 32-bpp frame buffer with a solid colour.
//   Writes go out as Avalon-MM write bursts of 64-bit words, two pixels per word.
//   Partial words at odd row edges are masked with byteenable.
//
// Ports
//   clock, reset_n            system clock, asynchronous active-low reset
//   cmd_valid/cmd_ready       command handshake (ready only while idle)
//   cmd_x0/x1, cmd_y0/y1      inclusive rectangle bounds
//   cmd_color                 fill colour {x,R,G,B}
//   busy, done, error         status; error is qualified by done
//   address, burstcount, write, writedata, byteenable, waitrequest, read
//                             Avalon-MM master (write-only)
//   debug_value0/1            beat / stall counters
//
// Optional feature: define FB_FILL_WRITER_STATS_EN to build the counters.
// Without it, debug_value0/1 are constant 0.
module fb_fill_writer #(
  parameter logic [29:0] ADDRESS   = 30'h3800_0000,
  parameter int unsigned WIDTH     = 800,
  parameter int unsigned HEIGHT    = 480,
  parameter int unsigned BURST_MAX = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_x0,
  input  logic [9:0]  cmd_x1,
  input  logic [9:0]  cmd_y0,
  input  logic [9:0]  cmd_y1,
  input  logic [31:0] cmd_color,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [28:0] address,
  output logic [7:0]  burstcount,
  input  logic        waitrequest,
  output logic [63:0] writedata,
  output logic [7:0]  byteenable,
  output logic        write,
  output logic        read,
  output logic [31:0] debug_value0,
  output logic [31:0] debug_value1
);

  localparam logic [28:0] BASE_WORD = 29'(ADDRESS >> 3);
  localparam logic [19:0] HALF_W    = 20'(WIDTH / 2);

  typedef enum logic [2:0] {IDLE, CHECK, SETUP, BURST, FINISH} state_t;

  state_t      state_q, state_d;
  logic [9:0]  x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d, y_q, y_d;
  logic [31:0] color_q, color_d;
  logic [19:0] word_q, word_d;
  logic [15:0] row_left_q, row_left_d;
  logic [7:0]  beats_left_q, beats_left_d;
  logic        first_q, first_d;
  logic        err_q, err_d;
  logic [28:0] address_q, address_d;
  logic [7:0]  burstcount_q, burstcount_d;

  logic [9:0]  y_next;
  logic [19:0] row_start;
  logic [15:0] row_beats;
  logic        invalid;
  logic [7:0]  be;

  // WIDTH is even, so every row starts on a fresh word offset by y*WIDTH/2
  // and the beat count per row depends only on x0/x1.
  always_comb begin
    y_next    = (state_q == CHECK) ? y0_q : y_q + 10'd1;
    row_start = 20'(y_next) * HALF_W + {11'b0, x0_q[9:1]};
    row_beats = {7'b0, x1_q[9:1]} - {7'b0, x0_q[9:1]} + 16'd1;
    invalid   = (x1_q < x0_q) || (y1_q < y0_q) ||
                (32'(x1_q) >= WIDTH) || (32'(y1_q) >= HEIGHT);
  end

  always_comb begin
    state_d      = state_q;
    x0_d         = x0_q;
    x1_d         = x1_q;
    y0_d         = y0_q;
    y1_d         = y1_q;
    y_d          = y_q;
    color_d      = color_q;
    word_d       = word_q;
    row_left_d   = row_left_q;
    beats_left_d = beats_left_q;
    first_d      = first_q;
    err_d        = err_q;
    address_d    = address_q;
    burstcount_d = burstcount_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          x0_d    = cmd_x0;
          x1_d    = cmd_x1;
          y0_d    = cmd_y0;
          y1_d    = cmd_y1;
          color_d = cmd_color;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (invalid) begin
          err_d   = 1'b1;
          state_d = FINISH;
        end else begin
          err_d      = 1'b0;
          y_d        = y0_q;
          word_d     = row_start;
          row_left_d = row_beats;
          first_d    = 1'b1;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        address_d    = BASE_WORD + 29'(word_q);
        burstcount_d = (row_left_q > 16'(BURST_MAX)) ? 8'(BURST_MAX) : row_left_q[7:0];
        beats_left_d = burstcount_d;
        state_d      = BURST;
      end
      BURST: begin
        if (!waitrequest) begin
          row_left_d   = row_left_q - 16'd1;
          beats_left_d = beats_left_q - 8'd1;
          word_d       = word_q + 20'd1;
          first_d      = 1'b0;
          if (beats_left_q == 8'd1) begin
            if (row_left_q != 16'd1) begin
              state_d = SETUP;
            end else if (y_q < y1_q) begin
              y_d        = y_q + 10'd1;
              word_d     = row_start;
              row_left_d = row_beats;
              first_d    = 1'b1;
              state_d    = SETUP;
            end else begin
              state_d = FINISH;
            end
          end
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      x0_q         <= '0;
      x1_q         <= '0;
      y0_q         <= '0;
      y1_q         <= '0;
      y_q          <= '0;
      color_q      <= '0;
      word_q       <= '0;
      row_left_q   <= '0;
      beats_left_q <= '0;
      first_q      <= 1'b0;
      err_q        <= 1'b0;
      address_q    <= '0;
      burstcount_q <= '0;
    end else begin
      state_q      <= state_d;
      x0_q         <= x0_d;
      x1_q         <= x1_d;
      y0_q         <= y0_d;
      y1_q         <= y1_d;
      y_q          <= y_d;
      color_q      <= color_d;
      word_q       <= word_d;
      row_left_q   <= row_left_d;
      beats_left_q <= beats_left_d;
      first_q      <= first_d;
      err_q        <= err_d;
      address_q    <= address_d;
      burstcount_q <= burstcount_d;
    end
  end

  // Edge masks derive from the row position registers, so they stay put
  // while waitrequest stalls a beat.
  always_comb begin
    be = 8'hFF;
    if (first_q && x0_q[0])                be = be & 8'hF0;
    if ((row_left_q == 16'd1) && !x1_q[0]) be = be & 8'h0F;
  end

  assign cmd_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == FINISH);
  assign error      = (state_q == FINISH) && err_q;
  assign write      = (state_q == BURST);
  assign read       = 1'b0;
  assign address    = address_q;
  assign burstcount = burstcount_q;
  assign writedata  = {color_q, color_q};
  assign byteenable = (state_q == BURST) ? be : '0;

`ifdef FB_FILL_WRITER_STATS_EN
  logic [31:0] beat_cnt_q, beat_cnt_d, stall_cnt_q, stall_cnt_d;

  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (write && !waitrequest) beat_cnt_d  = beat_cnt_q + 32'd1;
    if (write && waitrequest)  stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      beat_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign debug_value0 = beat_cnt_q;
  assign debug_value1 = stall_cnt_q;
`else
  assign debug_value0 = '0;
  assign debug_value1 = '0;
`endif

endmodule
